// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// Resolves load-use stalls, EX-resolved branch flushes and data-memory waits.
// A memory wait that exceeds WAIT_TIMEOUT cycles freezes the pipeline until reset.
module pipeline_hazard_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       i_id_rn,
    input  logic [3:0]       i_id_rm,
    input  logic             i_id_uses_rn,
    input  logic             i_id_uses_rm,
    input  logic [3:0]       i_ex_rd,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_reg_write,
    input  logic             i_ex_branch_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_idex_en,
    output logic             o_exmem_en,
    output logic             o_memwb_en,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_memwb_bubble,
    output logic             o_mem_fault,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_count
);

    typedef enum logic [1:0] {StRun, StMemWait, StFault} state_e;

    localparam logic [15:0]      LastWait = 16'(WAIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    state_e           r_state;
    state_e           w_state_next;
    logic [15:0]      r_wait_cnt;
    logic [15:0]      w_wait_next;
    logic             r_mem_fault;
    logic             w_fault_set;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    logic             w_mem_stall;
    logic             w_load_use;
    logic             w_count_stall;
    logic             w_count_flush;

    assign w_mem_stall = (r_state != StFault) & i_mem_req & ~i_mem_ready;
    assign w_load_use  = i_ex_mem_read & i_ex_reg_write &
                         ((i_id_uses_rn & (i_id_rn == i_ex_rd)) |
                          (i_id_uses_rm & (i_id_rm == i_ex_rd)));

    // Prioritised control outputs: reset, fault, mem stall, branch, load-use, normal.
    always_comb begin
        o_pc_en        = 1'b0;
        o_ifid_en      = 1'b0;
        o_idex_en      = 1'b0;
        o_exmem_en     = 1'b0;
        o_memwb_en     = 1'b0;
        o_ifid_flush   = 1'b0;
        o_idex_flush   = 1'b0;
        o_memwb_bubble = 1'b0;
        w_count_stall  = 1'b0;
        w_count_flush  = 1'b0;
        if (reset || r_state == StFault) begin
            // everything frozen
        end else if (w_mem_stall) begin
            // WB drains with a bubble so the held instruction does not write twice
            o_memwb_en     = 1'b1;
            o_memwb_bubble = 1'b1;
            w_count_stall  = 1'b1;
        end else if (i_ex_branch_taken) begin
            o_pc_en       = 1'b1;
            o_ifid_en     = 1'b1;
            o_idex_en     = 1'b1;
            o_exmem_en    = 1'b1;
            o_memwb_en    = 1'b1;
            o_ifid_flush  = 1'b1;
            o_idex_flush  = 1'b1;
            w_count_flush = 1'b1;
        end else if (w_load_use) begin
            o_idex_en     = 1'b1;
            o_idex_flush  = 1'b1;
            o_exmem_en    = 1'b1;
            o_memwb_en    = 1'b1;
            w_count_stall = 1'b1;
        end else begin
            o_pc_en    = 1'b1;
            o_ifid_en  = 1'b1;
            o_idex_en  = 1'b1;
            o_exmem_en = 1'b1;
            o_memwb_en = 1'b1;
        end
    end

    // Next-state and wait counter. The counter holds the number of stall cycles
    // already elapsed, so the detecting RUN cycle is wait cycle 0 and the first
    // MEM_WAIT cycle sees 1.
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait_cnt;
        w_fault_set  = 1'b0;
        unique case (r_state)
            StRun: begin
                if (w_mem_stall) begin
                    w_state_next = StMemWait;
                    w_wait_next  = 16'd1;
                end else begin
                    w_wait_next = 16'd0;
                end
            end
            StMemWait: begin
                if (!w_mem_stall) begin
                    w_state_next = StRun;
                    w_wait_next  = 16'd0;
                end else if (r_wait_cnt == LastWait) begin
                    w_state_next = StFault;
                    w_fault_set  = 1'b1;
                end else begin
                    w_wait_next = r_wait_cnt + 16'd1;
                end
            end
            StFault: begin
                w_state_next = StFault;
            end
            default: begin
                w_state_next = StRun;
                w_wait_next  = 16'd0;
            end
        endcase
    end

    // State, wait counter, sticky fault and saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= StRun;
            r_wait_cnt     <= 16'd0;
            r_mem_fault    <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
            if (w_fault_set) begin
                r_mem_fault <= 1'b1;
            end
            if (w_count_stall && r_stall_cycles != CntMax) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_count_flush && r_flush_count != CntMax) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign o_mem_fault    = r_mem_fault;
    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;

endmodule
